// File: rtl/player_input_ctrl_if.sv
// Button, frame-tick and heading signals between the input controller and its surroundings.
// The master modport drives the stimulus side; the slave modport is the controller.
interface player_input_ctrl_if;
  logic       en_cond;
  logic       collide;
  logic [3:0] p1_btn;
  logic [3:0] p2_btn;
  logic       start_btn;
  logic [3:0] p1_info;
  logic [3:0] p2_info;
  logic       dflt;

  modport master (
    output en_cond, collide, p1_btn, p2_btn, start_btn,
    input  p1_info, p2_info, dflt
  );

  modport slave (
    input  en_cond, collide, p1_btn, p2_btn, start_btn,
    output p1_info, p2_info, dflt
  );
endinterface

// File: rtl/player_input_ctrl.sv
// Player button conditioning, heading registers and IDLE/RUN/PAUSE/OVER game FSM.
// Optional PAUSE state is built only when PLAYER_INPUT_PAUSE_EN is defined.
module player_input_ctrl #(
  parameter int DB_CYCLES = 250000,
  parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic              clock,
  input  logic              reset,
  player_input_ctrl_if.slave bus
);

  localparam logic [3:0] P1_DEF = 4'b1000;
  localparam logic [3:0] P2_DEF = 4'b0100;
  localparam int unsigned NBTN  = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
`ifdef PLAYER_INPUT_PAUSE_EN
    PAUSE = 2'd2,
`endif
    OVER  = 2'd3
  } state_t;

  state_t state;

  logic [NBTN-1:0]  raw;
  logic [NBTN-1:0]  sync1;
  logic [NBTN-1:0]  sync2;
  logic [NBTN-1:0]  deb;
  logic [CNT_W-1:0] cnt [NBTN];
  logic             start_q;
  logic             start_pe;

  logic [3:0] p1_cur, p1_pend, p2_cur, p2_pend;
  logic [3:0] p1_db, p2_db;
  logic [3:0] p1_nxt, p2_nxt;
  logic       p1_ok, p2_ok;

  assign raw = {bus.start_btn, bus.p2_btn, bus.p1_btn};

  // Each button flips its debounced level only after a full run of mismatching cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      deb     <= '0;
      start_q <= 1'b0;
      for (int unsigned i = 0; i < NBTN; i++) cnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      start_q <= deb[8];
      for (int unsigned i = 0; i < NBTN; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign start_pe = deb[8] & ~start_q;
  assign p1_db    = deb[3:0];
  assign p2_db    = deb[7:4];

  function automatic logic turn_ok(input logic [3:0] b, input logic [3:0] c);
    logic [3:0] rev;
    rev = {c[2], c[3], c[0], c[1]};
    return (b != 4'b0000) && ((b & (b - 4'b0001)) == 4'b0000) && (b != rev);
  endfunction

  assign p1_ok  = turn_ok(p1_db, p1_cur);
  assign p2_ok  = turn_ok(p2_db, p2_cur);
  assign p1_nxt = bus.en_cond ? p1_pend : p1_cur;
  assign p2_nxt = bus.en_cond ? p2_pend : p2_cur;

  // Outputs are registered from the post-edge state and heading, so they track the state edge itself.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      bus.dflt    <= 1'b1;
      bus.p1_info <= '0;
      bus.p2_info <= '0;
      p1_cur      <= P1_DEF;
      p1_pend     <= P1_DEF;
      p2_cur      <= P2_DEF;
      p2_pend     <= P2_DEF;
    end else begin
      case (state)
        IDLE: begin
          p1_cur  <= P1_DEF;
          p1_pend <= P1_DEF;
          p2_cur  <= P2_DEF;
          p2_pend <= P2_DEF;
          if (start_pe) begin
            state       <= RUN;
            bus.dflt    <= 1'b0;
            bus.p1_info <= P1_DEF;
            bus.p2_info <= P2_DEF;
          end
        end
        RUN: begin
          if (p1_ok) p1_pend <= p1_db;
          if (p2_ok) p2_pend <= p2_db;
          p1_cur <= p1_nxt;
          p2_cur <= p2_nxt;
          if (bus.collide) begin
            state       <= OVER;
            bus.p1_info <= '0;
            bus.p2_info <= '0;
`ifdef PLAYER_INPUT_PAUSE_EN
          end else if (start_pe) begin
            state       <= PAUSE;
            bus.p1_info <= '0;
            bus.p2_info <= '0;
`endif
          end else begin
            bus.p1_info <= p1_nxt;
            bus.p2_info <= p2_nxt;
          end
        end
`ifdef PLAYER_INPUT_PAUSE_EN
        PAUSE: begin
          if (start_pe) begin
            state       <= RUN;
            bus.p1_info <= p1_cur;
            bus.p2_info <= p2_cur;
          end
        end
`endif
        OVER: begin
          if (start_pe) begin
            state    <= IDLE;
            bus.dflt <= 1'b1;
            p1_cur   <= P1_DEF;
            p1_pend  <= P1_DEF;
            p2_cur   <= P2_DEF;
            p2_pend  <= P2_DEF;
          end
        end
        default: begin
          state       <= IDLE;
          bus.dflt    <= 1'b1;
          bus.p1_info <= '0;
          bus.p2_info <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed vector bench for player_input_ctrl with a short debounce window.
module tb_player_input_ctrl;

  localparam int DB = 4;
`ifdef PLAYER_INPUT_PAUSE_EN
  localparam bit PZ = 1'b1;
`else
  localparam bit PZ = 1'b0;
`endif

  typedef struct {
    string      name;
    logic       rst;
    logic       start;
    logic       en;
    logic       col;
    logic [3:0] p1b;
    logic [3:0] p2b;
    int         cyc;
    logic       e_dflt;
    logic [3:0] e_p1;
    logic [3:0] e_p2;
  } vec_t;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_err;
  vec_t vecs[$];

  player_input_ctrl_if bus ();

  player_input_ctrl #(.DB_CYCLES(DB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic add(input string nm, input logic r, input logic s, input logic e,
                     input logic c, input logic [3:0] b1, input logic [3:0] b2,
                     input int n, input logic d, input logic [3:0] x1, input logic [3:0] x2);
    vec_t v;
    v.name = nm; v.rst = r; v.start = s; v.en = e; v.col = c;
    v.p1b = b1; v.p2b = b2; v.cyc = n; v.e_dflt = d; v.e_p1 = x1; v.e_p2 = x2;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic d, input logic [3:0] x1, input logic [3:0] x2);
    n_vec++;
    if (bus.dflt !== d || bus.p1_info !== x1 || bus.p2_info !== x2) begin
      n_err++;
      $display("FAIL %s: got dflt=%b p1=%b p2=%b, want dflt=%b p1=%b p2=%b",
               nm, bus.dflt, bus.p1_info, bus.p2_info, d, x1, x2);
    end
  endtask

  initial begin
    logic [3:0] pz1, pz2;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.en_cond = 1'b0; bus.collide = 1'b0; bus.start_btn = 1'b0;
    bus.p1_btn = '0; bus.p2_btn = '0;

    pz1 = PZ ? 4'b0000 : 4'b0001;
    pz2 = PZ ? 4'b0000 : 4'b0010;

    //   name            rst s  en col p1b      p2b      cyc dflt p1       p2
    add("reset",         1, 0, 0, 0, 4'b0000, 4'b0000, 2, 1, 4'b0000, 4'b0000);
    add("start_wait",    0, 1, 0, 0, 4'b0000, 4'b0000, 6, 1, 4'b0000, 4'b0000);
    add("start_run",     0, 1, 0, 0, 4'b0000, 4'b0000, 1, 0, 4'b1000, 4'b0100);
    add("start_hold",    0, 1, 0, 0, 4'b0000, 4'b0000, 3, 0, 4'b1000, 4'b0100);
    add("start_release", 0, 0, 0, 0, 4'b0000, 4'b0000, 8, 0, 4'b1000, 4'b0100);
    add("glitch_hi",     0, 0, 0, 0, 4'b0001, 4'b0000, 3, 0, 4'b1000, 4'b0100);
    add("glitch_lo",     0, 0, 0, 0, 4'b0000, 4'b0000, 5, 0, 4'b1000, 4'b0100);
    add("glitch_commit", 0, 0, 1, 0, 4'b0000, 4'b0000, 1, 0, 4'b1000, 4'b0100);
    add("rev_hold",      0, 0, 0, 0, 4'b0100, 4'b1000, 7, 0, 4'b1000, 4'b0100);
    add("rev_commit",    0, 0, 1, 0, 4'b0100, 4'b1000, 1, 0, 4'b1000, 4'b0100);
    add("rev_release",   0, 0, 0, 0, 4'b0000, 4'b0000, 8, 0, 4'b1000, 4'b0100);
    add("two_hold",      0, 0, 0, 0, 4'b0011, 4'b0011, 7, 0, 4'b1000, 4'b0100);
    add("two_commit",    0, 0, 1, 0, 4'b0011, 4'b0011, 1, 0, 4'b1000, 4'b0100);
    add("two_release",   0, 0, 0, 0, 4'b0000, 4'b0000, 8, 0, 4'b1000, 4'b0100);
    add("turn_hold",     0, 0, 0, 0, 4'b0001, 4'b0010, 7, 0, 4'b1000, 4'b0100);
    add("turn_commit",   0, 0, 1, 0, 4'b0001, 4'b0010, 1, 0, 4'b0001, 4'b0010);
    add("turn_release",  0, 0, 0, 0, 4'b0000, 4'b0000, 8, 0, 4'b0001, 4'b0010);
    add("pause_wait",    0, 1, 0, 0, 4'b0000, 4'b0000, 6, 0, 4'b0001, 4'b0010);
    add("pause_enter",   0, 1, 0, 0, 4'b0000, 4'b0000, 1, 0, pz1,     pz2);
    add("pause_hold",    0, 1, 0, 0, 4'b0000, 4'b0000, 3, 0, pz1,     pz2);
    add("pause_release", 0, 0, 0, 0, 4'b0000, 4'b0000, 8, 0, pz1,     pz2);
    add("pause_tick",    0, 0, 1, 0, 4'b0000, 4'b0000, 1, 0, pz1,     pz2);
    add("resume_wait",   0, 1, 0, 0, 4'b0000, 4'b0000, 6, 0, pz1,     pz2);
    add("resume",        0, 1, 0, 0, 4'b0000, 4'b0000, 1, 0, 4'b0001, 4'b0010);
    add("resume_hold",   0, 1, 0, 0, 4'b0000, 4'b0000, 3, 0, 4'b0001, 4'b0010);
    add("resume_rel",    0, 0, 0, 0, 4'b0000, 4'b0000, 8, 0, 4'b0001, 4'b0010);
    add("col_wait",      0, 1, 0, 0, 4'b0000, 4'b0000, 6, 0, 4'b0001, 4'b0010);
    add("col_and_start", 0, 1, 0, 1, 4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b0000);
    add("over_hold",     0, 1, 0, 0, 4'b0000, 4'b0000, 3, 0, 4'b0000, 4'b0000);
    add("over_release",  0, 0, 0, 0, 4'b0000, 4'b0000, 8, 0, 4'b0000, 4'b0000);
    add("over_col",      0, 0, 0, 1, 4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b0000);
    add("over_btn",      0, 0, 1, 0, 4'b0001, 4'b0001, 8, 0, 4'b0000, 4'b0000);
    add("idle_wait",     0, 1, 0, 0, 4'b0000, 4'b0000, 6, 0, 4'b0000, 4'b0000);
    add("idle_enter",    0, 1, 0, 0, 4'b0000, 4'b0000, 1, 1, 4'b0000, 4'b0000);
    add("idle_hold",     0, 1, 0, 0, 4'b0000, 4'b0000, 3, 1, 4'b0000, 4'b0000);
    add("idle_release",  0, 0, 0, 0, 4'b0000, 4'b0000, 8, 1, 4'b0000, 4'b0000);
    add("idle_col",      0, 0, 1, 1, 4'b0000, 4'b0000, 1, 1, 4'b0000, 4'b0000);
    add("run2_wait",     0, 1, 0, 0, 4'b0000, 4'b0000, 6, 1, 4'b0000, 4'b0000);
    add("run2_defaults", 0, 1, 0, 0, 4'b0000, 4'b0000, 1, 0, 4'b1000, 4'b0100);
    add("mid_reset",     1, 1, 0, 0, 4'b0000, 4'b0000, 1, 1, 4'b0000, 4'b0000);
    add("after_reset",   0, 0, 0, 0, 4'b0000, 4'b0000, 8, 1, 4'b0000, 4'b0000);

    @(negedge clock);
    foreach (vecs[i]) begin
      reset         = vecs[i].rst;
      bus.start_btn = vecs[i].start;
      bus.en_cond   = vecs[i].en;
      bus.collide   = vecs[i].col;
      bus.p1_btn    = vecs[i].p1b;
      bus.p2_btn    = vecs[i].p2b;
      repeat (vecs[i].cyc) @(posedge clock);
      @(negedge clock);
      check(vecs[i].name, vecs[i].e_dflt, vecs[i].e_p1, vecs[i].e_p2);
    end

    // Cycle-exact start latency: RUN outputs appear 7 edges after the raw press.
    reset = 1'b0; bus.en_cond = 1'b0; bus.collide = 1'b0;
    bus.p1_btn = '0; bus.p2_btn = '0;
    bus.start_btn = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (k < 7) check($sformatf("lat_idle_%0d", k), 1'b1, 4'b0000, 4'b0000);
      else       check($sformatf("lat_run_%0d", k),  1'b0, 4'b1000, 4'b0100);
    end

    // Commit latency: heading stays until the edge that samples en_cond.
    bus.start_btn = 1'b0;
    bus.p2_btn = 4'b0001;
    repeat (7) @(posedge clock);
    @(negedge clock);
    check("lat_pend_only", 1'b0, 4'b1000, 4'b0100);
    bus.en_cond = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.en_cond = 1'b0;
    check("lat_commit", 1'b0, 4'b1000, 4'b0001);
    @(posedge clock);
    @(negedge clock);
    check("lat_commit_hold", 1'b0, 4'b1000, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
